// File: rtl/mmu_pkg.sv
// Shared constants for the MMU: window geometry, register offsets and
// the commit-sequencer state encoding.
package mmu_pkg;

    localparam int NUM_BANKS = 16;
    localparam int BANK_W    = 7;
    localparam int PHYS_W    = 19;
    localparam int IDX_W     = $clog2(NUM_BANKS);
    localparam int OFS_W     = 5;
    localparam int DELAY_W   = 3;

    // Register window offsets, decoded from cpu_addr[4:0].
    localparam logic [OFS_W-1:0] REG_SHADOW     = 5'h00;
    localparam logic [OFS_W-1:0] REG_COMMIT     = 5'h10;
    localparam logic [OFS_W-1:0] REG_STATUS     = 5'h11;
    localparam logic [OFS_W-1:0] REG_ACTIVE_SEL = 5'h12;
    localparam logic [OFS_W-1:0] REG_ACTIVE_RD  = 5'h13;

    // Commit sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_COUNT = 2'b01;
    localparam logic [1:0] ST_APPLY = 2'b10;

    // STATUS register layout: {busy, 4'b0, state, 1'b0}.
    function automatic logic [7:0] status_byte(input logic busy, input logic [1:0] state);
        return {busy, 4'b0000, state, 1'b0};
    endfunction

endpackage

// File: rtl/mmu_bank_file.sv
// Shadow and active bank register arrays. Software edits the shadow copy;
// the active copy drives address translation and only changes on apply.
module mmu_bank_file import mmu_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    input  logic              shadow_we,
    input  logic [IDX_W-1:0]  shadow_idx,
    input  logic [BANK_W-1:0] shadow_wdata,
    input  logic              apply,
    input  logic [IDX_W-1:0]  active_sel,
    input  logic [IDX_W-1:0]  window,
    output logic [BANK_W-1:0] shadow_rdata,
    output logic [BANK_W-1:0] active_rdata,
    output logic [BANK_W-1:0] window_bank
);

    logic [BANK_W-1:0] shadow [NUM_BANKS];
    logic [BANK_W-1:0] active [NUM_BANKS];

    // Shadow array: reset to identity, then written by the CPU in any state.
    // NOTE: non-blocking assignments here let the active array below sample
    // the pre-write shadow value on an edge where both change.
    // NOTE: these arrays are reset element by element because the identity
    // mapping must be valid from the first cycle; this keeps them in flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                shadow[i] <= BANK_W'(i);
            end
        end else if (shadow_we) begin
            shadow[shadow_idx] <= shadow_wdata;
        end
    end

    // Active array: reset to identity, bulk-copied from shadow on apply only.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                active[i] <= BANK_W'(i);
            end
        end else if (apply) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    assign shadow_rdata = shadow[shadow_idx];
    assign active_rdata = active[active_sel];
    assign window_bank  = active[window];

endmodule

// File: rtl/mmu.sv
// Bank-switching MMU: 16 x 4 KiB logical windows mapped onto a 19-bit
// physical space, with a register window for staging and a delayed commit.
module mmu import mmu_pkg::*; (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic              rw,
    input  logic              cs,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [PHYS_W-1:0] phys_addr,
    output logic              busy
);

    logic [OFS_W-1:0]   reg_ofs;
    logic               wr_en;
    logic               shadow_we;
    logic               commit_we;
    logic               sel_we;
    logic [1:0]         state;
    logic [DELAY_W-1:0] counter;
    logic [DELAY_W-1:0] commit_delay;
    logic [IDX_W-1:0]   active_sel;
    logic               apply;
    logic [BANK_W-1:0]  shadow_rdata;
    logic [BANK_W-1:0]  active_rdata;
    logic [BANK_W-1:0]  window_bank;
    logic [7:0]         read_data;
    logic               unused_data_msb;

    assign reg_ofs      = cpu_addr[OFS_W-1:0];
    assign wr_en        = !cs && !rw;
    assign shadow_we    = wr_en && !reg_ofs[4];
    assign commit_we    = wr_en && (reg_ofs == REG_COMMIT);
    assign sel_we       = wr_en && (reg_ofs == REG_ACTIVE_SEL);
    assign commit_delay = data_in[DELAY_W-1:0];
    assign apply        = (state == ST_APPLY);
    assign busy         = (state != ST_IDLE);
    assign data_oe      = !cs && rw;

    // Bit 7 of every register is reserved and never stored.
    assign unused_data_msb = data_in[7];

    mmu_bank_file u_bank_file (
        .clock        (clock),
        .reset        (reset),
        .shadow_we    (shadow_we),
        .shadow_idx   (reg_ofs[IDX_W-1:0]),
        .shadow_wdata (data_in[BANK_W-1:0]),
        .apply        (apply),
        .active_sel   (active_sel),
        .window       (cpu_addr[15:12]),
        .shadow_rdata (shadow_rdata),
        .active_rdata (active_rdata),
        .window_bank  (window_bank)
    );

    // Zero-latency translation through the active bank of the addressed window.
    assign phys_addr = {window_bank, cpu_addr[11:0]};

    // Commit sequencer: optional countdown, then a single apply cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit_we) begin
                        if (commit_delay == '0) begin
                            state <= ST_APPLY;
                        end else begin
                            counter <= commit_delay;
                            state   <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    counter <= counter - 1'b1;
                    if (counter == DELAY_W'(1)) begin
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ACTIVE_SEL register: picks which active bank ACTIVE_RD returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_sel <= '0;
        end else if (sel_we) begin
            active_sel <= data_in[IDX_W-1:0];
        end
    end

    // Register read mux; reserved offsets read as zero.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        read_data = 8'h00;
        if (!reg_ofs[4]) begin
            read_data = {1'b0, shadow_rdata};
        end else begin
            case (reg_ofs)
                REG_STATUS:     read_data = status_byte(busy, state);
                REG_ACTIVE_SEL: read_data = {4'b0000, active_sel};
                REG_ACTIVE_RD:  read_data = {1'b0, active_rdata};
                default:        read_data = 8'h00;
            endcase
        end
    end

    assign data_out = data_oe ? read_data : 8'h00;

endmodule

// File: tb/tb_mmu.sv
// Self-checking bench for the MMU: directed scenarios with a scoreboard
// queue of expected values consumed as DUT outputs are sampled.
`timescale 1ns/1ps
module tb_mmu;
    import mmu_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic [15:0]       cpu_addr;
    logic              rw;
    logic              cs;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              data_oe;
    logic [PHYS_W-1:0] phys_addr;
    logic              busy;

    always #5 clock = ~clock;

    mmu dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .rw        (rw),
        .cs        (cs),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .phys_addr (phys_addr),
        .busy      (busy)
    );

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // All stimulus starts just after a falling edge; samples take #1 each.
    task automatic reg_write(input logic [4:0] ofs, input logic [7:0] d);
        cs       = 1'b0;
        rw       = 1'b0;
        cpu_addr = {11'h000, ofs};
        data_in  = d;
        @(negedge clock);
        cs = 1'b1;
        rw = 1'b1;
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] ofs, input logic [7:0] exp);
        cs       = 1'b0;
        rw       = 1'b1;
        cpu_addr = {11'h000, ofs};
        sb_push(tag, 32'(exp));
        sb_push({tag, "_oe"}, 32'd1);
        #1;
        sb_pop(32'(data_out));
        sb_pop(32'(data_oe));
        cs = 1'b1;
    endtask

    task automatic expect_map(input string tag, input logic [15:0] a,
                              input logic [18:0] exp_phys, input logic exp_busy);
        cs       = 1'b1;
        rw       = 1'b1;
        cpu_addr = a;
        sb_push(tag, 32'(exp_phys));
        sb_push({tag, "_busy"}, 32'(exp_busy));
        #1;
        sb_pop(32'(phys_addr));
        sb_pop(32'(busy));
    endtask

    // Bus must stay released unless cs is low and rw is high.
    task automatic expect_bus_off(input string tag, input logic cs_v, input logic rw_v);
        cs       = cs_v;
        rw       = rw_v;
        cpu_addr = 16'h001F;
        sb_push({tag, "_oe"}, 32'd0);
        sb_push({tag, "_data"}, 32'd0);
        #1;
        sb_pop(32'(data_oe));
        sb_pop(32'(data_out));
        cs = 1'b1;
        rw = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        cs       = 1'b1;
        rw       = 1'b1;
        cpu_addr = 16'h0000;
        data_in  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state: identity map, idle, registers at reset values.
        expect_map("rst_phys_c123", 16'hC123, 19'h0C123, 1'b0);
        expect_reg("rst_status", REG_STATUS, 8'h00);
        expect_reg("rst_shadow3", 5'h03, 8'h03);
        expect_reg("rst_sel", REG_ACTIVE_SEL, 8'h00);
        expect_reg("reserved_15", 5'h15, 8'h00);
        expect_bus_off("bus_cs_high", 1'b1, 1'b1);
        expect_bus_off("bus_write", 1'b0, 1'b0);
        @(negedge clock);

        // D=0 commit: shadow alone never moves the map; apply on the next edge.
        reg_write(5'h0C, 8'h45);
        expect_reg("shadow_c", 5'h0C, 8'h45);
        expect_map("d0_pre", 16'hC123, 19'h0C123, 1'b0);
        reg_write(REG_COMMIT, 8'h00);
        for (int n = 0; n < 4; n++) begin
            expect_map($sformatf("d0_n%0d", n), 16'hC123,
                       (n >= 1) ? 19'h45123 : 19'h0C123, n < 1);
            if (n == 0) expect_reg("d0_status_apply", REG_STATUS, 8'h84);
            @(negedge clock);
        end

        // D=5 commit; bit 7 of the shadow write is dropped.
        reg_write(5'h02, 8'hFF);
        expect_reg("shadow_2_msb", 5'h02, 8'h7F);
        reg_write(REG_COMMIT, 8'h05);
        for (int n = 0; n < 9; n++) begin
            expect_map($sformatf("d5_n%0d", n), 16'h2ABC,
                       (n >= 6) ? 19'h7FABC : 19'h02ABC, n < 6);
            if (n == 0) expect_reg("d5_status_count", REG_STATUS, 8'h82);
            if (n == 5) expect_reg("d5_status_apply", REG_STATUS, 8'h84);
            if (n == 6) expect_reg("d5_status_idle", REG_STATUS, 8'h00);
            @(negedge clock);
        end

        // COMMIT while busy is ignored: apply stays at the first commit's schedule.
        reg_write(5'h01, 8'h33);
        reg_write(REG_COMMIT, 8'h03);
        @(negedge clock);
        reg_write(REG_COMMIT, 8'h07);
        for (int n = 2; n < 10; n++) begin
            expect_map($sformatf("dbl_n%0d", n), 16'h1234,
                       (n >= 4) ? 19'h33234 : 19'h01234, n < 4);
            @(negedge clock);
        end
        reg_write(5'h01, 8'h22);
        for (int n = 0; n < 5; n++) begin
            expect_map($sformatf("dbl_no_late_n%0d", n), 16'h1234, 19'h33234, 1'b0);
            @(negedge clock);
        end

        // Reset during COUNT aborts the commit and wins over a simultaneous write.
        reg_write(REG_ACTIVE_SEL, 8'h09);
        reg_write(5'h04, 8'h0A);
        reg_write(REG_COMMIT, 8'h04);
        @(negedge clock);
        expect_map("abort_pre", 16'h4567, 19'h04567, 1'b1);
        reset    = 1'b1;
        cs       = 1'b0;
        rw       = 1'b0;
        cpu_addr = 16'h0004;
        data_in  = 8'h55;
        @(negedge clock);
        reset = 1'b0;
        cs    = 1'b1;
        rw    = 1'b1;
        expect_map("abort_c", 16'hC123, 19'h0C123, 1'b0);
        expect_map("abort_2", 16'h2ABC, 19'h02ABC, 1'b0);
        expect_reg("abort_shadow4", 5'h04, 8'h04);
        expect_reg("abort_sel", REG_ACTIVE_SEL, 8'h00);
        @(negedge clock);
        for (int n = 0; n < 8; n++) begin
            expect_map($sformatf("abort_n%0d", n), 16'h4567, 19'h04567, 1'b0);
            @(negedge clock);
        end

        // Shadow write on the apply edge: active takes the old shadow value.
        reg_write(5'h05, 8'h66);
        reg_write(REG_COMMIT, 8'h00);
        reg_write(5'h05, 8'h11);
        reg_write(REG_ACTIVE_SEL, 8'h05);
        expect_reg("race_sel", REG_ACTIVE_SEL, 8'h05);
        expect_reg("race_active5", REG_ACTIVE_RD, 8'h66);
        expect_reg("race_shadow5", 5'h05, 8'h11);
        expect_map("race_phys", 16'h5000, 19'h66000, 1'b0);
        @(negedge clock);
        reg_write(REG_COMMIT, 8'h00);
        @(negedge clock);
        expect_reg("race_active5_new", REG_ACTIVE_RD, 8'h11);
        expect_map("race_phys_new", 16'h5ABC, 19'h11ABC, 1'b0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
